rec_buf_rot_n: RTL

Parametrised N-bank rotating memory buffer for the reconstruction pipeline. Data for one LCU is written at stage 0 and read back N-1 rotations later at stage N-1. Each bank is a single-port RAM. Rotation is either an external strobe or an internal producer/consumer done-handshake. Per-bank fill tracking makes a read of a bank never written since it entered stage 0 return zero, not stale data.

---
 rtl/rec_buf_rot_n.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rec_buf_rot_n.sv
// N-bank rotating buffer: stage 0 writes, stage BUF_NUM-1 reads, banks
// advance one stage per rotation. Per-bank fill flags make banks that were
// not written since entering stage 0 read back as zero.
module rec_buf_rot_n #(
  parameter int unsigned DAT_WID  = 23,
  parameter int unsigned ADR_WID  = 6,
  parameter int unsigned BUF_NUM  = 3,
  parameter int unsigned ROT_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       rotate_i,
  input  logic                       wr_done_i,
  input  logic                       rd_done_i,
  input  logic                       wr_ena_i,
  input  logic [ADR_WID-1:0]         wr_adr_i,
  input  logic [DAT_WID-1:0]         wr_dat_i,
  input  logic                       rd_ena_i,
  input  logic [ADR_WID-1:0]         rd_adr_i,
  output logic [DAT_WID-1:0]         rd_dat_o,
  output logic                       rd_vld_o,
  output logic                       rot_o,
  output logic [$clog2(BUF_NUM)-1:0] rot_ptr_o,
  output logic                       wr_pend_o,
  output logic                       rd_pend_o
);

  localparam int unsigned PTR_W = $clog2(BUF_NUM);
  localparam int unsigned DEPTH = 1 << ADR_WID;

  typedef logic [PTR_W-1:0] ptr_t;

  // Handshake state: at most one side can be pending, since both pending
  // means the rotation has already happened.
  typedef enum logic [1:0] {
    HS_IDLE,
    HS_WR_PEND,
    HS_RD_PEND
  } hs_state_e;

  hs_state_e          hs_q, hs_d;
  ptr_t               ptr_q, ptr_d;
  logic [BUF_NUM-1:0] fill_q, fill_d;
  logic               rot_ev;
  logic               rot_q;
  logic               rd_vld_q;
  logic               rd_hit_q;
  ptr_t               rd_bank_q;
  ptr_t               wr_bank, rd_bank, nxt_wr_bank;
  logic [DAT_WID-1:0] bank_dout [BUF_NUM];

  // Stage-to-bank mapping for the current pointer, and the bank that
  // becomes stage 0 after the next rotation.
  always_comb begin
    wr_bank     = (ptr_q == '0) ? '0 : ptr_t'(BUF_NUM) - ptr_q;
    rd_bank     = ptr_t'(BUF_NUM - 1) - ptr_q;
    nxt_wr_bank = (wr_bank == '0) ? ptr_t'(BUF_NUM - 1) : wr_bank - ptr_t'(1);
  end

  // Rotation event and handshake next state.
  always_comb begin
    rot_ev = 1'b0;
    hs_d   = hs_q;
    if (ROT_MODE == 0) begin
      rot_ev = rotate_i;
      hs_d   = HS_IDLE;
    end else begin
      rot_ev = ((hs_q == HS_WR_PEND) || wr_done_i) &&
               ((hs_q == HS_RD_PEND) || rd_done_i);
      if (rot_ev) begin
        hs_d = HS_IDLE;
      end else if (wr_done_i) begin
        hs_d = HS_WR_PEND;
      end else if (rd_done_i) begin
        hs_d = HS_RD_PEND;
      end
    end
  end

  // Pointer advance with wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (rot_ev) begin
      ptr_d = (ptr_q == ptr_t'(BUF_NUM - 1)) ? '0 : ptr_q + ptr_t'(1);
    end
  end

  // Fill flags: set by stage-0 writes, cleared when a bank re-enters stage 0.
  always_comb begin
    fill_d = fill_q;
    if (wr_ena_i) begin
      fill_d[wr_bank] = 1'b1;
    end
    if (rot_ev && !(wr_ena_i && (wr_bank == nxt_wr_bank))) begin
      fill_d[nxt_wr_bank] = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hs_q      <= HS_IDLE;
      ptr_q     <= '0;
      fill_q    <= '0;
      rot_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_hit_q  <= 1'b0;
      rd_bank_q <= '0;
    end else begin
      hs_q     <= hs_d;
      ptr_q    <= ptr_d;
      fill_q   <= fill_d;
      rot_q    <= rot_ev;
      rd_vld_q <= rd_ena_i;
      if (rd_ena_i) begin
        rd_hit_q  <= fill_q[rd_bank];
        rd_bank_q <= rd_bank;
      end
    end
  end

  // One single-port RAM per bank; output register only moves on a read so
  // the selected word holds between reads.
  for (genvar b = 0; b < BUF_NUM; b++) begin : g_bank
    logic               we;
    logic               rd_sel;
    logic               ena;
    logic [ADR_WID-1:0] adr;
    logic [DAT_WID-1:0] mem_q [DEPTH];
    logic [DAT_WID-1:0] dout_q;

    assign we     = wr_ena_i && (wr_bank == ptr_t'(b));
    assign rd_sel = rd_ena_i && (rd_bank == ptr_t'(b));
    assign ena    = we || rd_sel;
    assign adr    = rd_sel ? rd_adr_i : wr_adr_i;

    // RAM array and read register, intentionally not reset.
    always_ff @(posedge clk) begin
      if (ena) begin
        if (we) begin
          mem_q[adr] <= wr_dat_i;
        end else begin
          dout_q <= mem_q[adr];
        end
      end
    end

    assign bank_dout[b] = dout_q;
  end

  // A read of an unfilled bank presents zero instead of stale RAM content.
  assign rd_dat_o  = rd_hit_q ? bank_dout[rd_bank_q] : '0;
  assign rd_vld_o  = rd_vld_q;
  assign rot_o     = rot_q;
  assign rot_ptr_o = ptr_q;
  assign wr_pend_o = (hs_q == HS_WR_PEND);
  assign rd_pend_o = (hs_q == HS_RD_PEND);

endmodule
